// File: rtl/exec_mem_unit.sv
// Execute/memory block for the multicycle datapath: a 32-bit combinational ALU
// plus word-addressed instruction and data memories (sync write, async read).
module exec_mem_unit #(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        alu_a,
    input  logic [31:0]        alu_b,
    input  logic [3:0]         alu_sel,
    output logic [31:0]        alu_result,
    output logic               alu_eq,
    output logic               alu_zero,
    input  logic [31:0]        imem_addr,
    output logic [31:0]        imem_instr,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_waddr,
    input  logic [31:0]        imem_wdata,
    input  logic [15:0]        dmem_addr,
    input  logic [31:0]        dmem_wdata,
    input  logic               dmem_we,
    output logic [31:0]        dmem_rdata
);

    localparam int IMEM_DEPTH = 1 << IMEM_AW;
    localparam int DMEM_DEPTH = 1 << DMEM_AW;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_PASSB = 4'd2;
    localparam logic [3:0] OP_NOTA  = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_NOR   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SLL   = 4'd10;
    localparam logic [3:0] OP_SRA   = 4'd11;
    localparam logic [3:0] OP_PASSA = 4'd12;
    localparam logic [3:0] OP_INC   = 4'd13;
    localparam logic [3:0] OP_DEC   = 4'd14;

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic        [4:0]  shamt;

    // Upper address bits are deliberately ignored so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_addr[31:IMEM_AW], dmem_addr[15:DMEM_AW]};

    assign a_s   = alu_a;
    assign b_s   = alu_b;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_result = 32'h0;
        case (alu_sel)
            OP_ADD:   alu_result = alu_a + alu_b;
            OP_SUB:   alu_result = alu_a - alu_b;
            OP_PASSB: alu_result = alu_b;
            OP_NOTA:  alu_result = ~alu_a;
            OP_AND:   alu_result = alu_a & alu_b;
            OP_OR:    alu_result = alu_a | alu_b;
            OP_XOR:   alu_result = alu_a ^ alu_b;
            OP_SLT:   alu_result = {31'h0, (a_s < b_s)};
            OP_NOR:   alu_result = ~(alu_a | alu_b);
            OP_SRL:   alu_result = alu_a >> shamt;
            OP_SLL:   alu_result = alu_a << shamt;
            OP_SRA:   alu_result = a_s >>> shamt;
            OP_PASSA: alu_result = alu_a;
            OP_INC:   alu_result = alu_a + 32'd1;
            OP_DEC:   alu_result = alu_a - 32'd1;
            default:  alu_result = 32'h0;
        endcase
    end

    assign alu_eq   = (alu_a == alu_b);
    assign alu_zero = (alu_result == 32'h0);

    assign imem_instr = imem[imem_addr[IMEM_AW-1:0]];
    assign dmem_rdata = dmem[dmem_addr[DMEM_AW-1:0]];

    // Reset clears every word and overrides any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IMEM_DEPTH; i++) begin
                imem[i] <= 32'h0;
            end
            for (int j = 0; j < DMEM_DEPTH; j++) begin
                dmem[j] <= 32'h0;
            end
        end else begin
            if (imem_we) begin
                imem[imem_waddr] <= imem_wdata;
            end
            if (dmem_we) begin
                dmem[dmem_addr[DMEM_AW-1:0]] <= dmem_wdata;
            end
        end
    end

endmodule

// File: tb/tb_exec_mem_unit.sv
// Scoreboard bench for exec_mem_unit: expectations are queued as stimulus is
// applied and drained once the combinational outputs have settled.
module tb_exec_mem_unit;

    localparam int IMEM_AW = 8;
    localparam int DMEM_AW = 8;

    localparam int SEL_RES  = 0;
    localparam int SEL_EQ   = 1;
    localparam int SEL_ZERO = 2;
    localparam int SEL_INSTR = 3;
    localparam int SEL_DATA = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        alu_a, alu_b;
    logic [3:0]         alu_sel;
    logic [31:0]        alu_result;
    logic               alu_eq, alu_zero;
    logic [31:0]        imem_addr;
    logic [31:0]        imem_instr;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [31:0]        imem_wdata;
    logic [15:0]        dmem_addr;
    logic [31:0]        dmem_wdata;
    logic               dmem_we;
    logic [31:0]        dmem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q [$];
    int          sel_q [$];
    string       tag_q [$];

    exec_mem_unit #(.IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW)) dut (
        .clk(clk), .rst(rst),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_eq(alu_eq), .alu_zero(alu_zero),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input int sel, input logic [31:0] exp, input string tag);
        sel_q.push_back(sel);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic drain();
        int          sel;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            sel = sel_q.pop_front();
            case (sel)
                SEL_RES:   obs = alu_result;
                SEL_EQ:    obs = {31'h0, alu_eq};
                SEL_ZERO:  obs = {31'h0, alu_zero};
                SEL_INSTR: obs = imem_instr;
                default:   obs = dmem_rdata;
            endcase
            check_val(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_chk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                           input logic [31:0] exp, input string tag);
        alu_a = a; alu_b = b; alu_sel = sel;
        expect_out(SEL_RES, exp, tag);
        expect_out(SEL_ZERO, {31'h0, (exp == 32'h0)}, {tag, "_zero"});
        #1;
        drain();
    endtask

    initial begin
        rst = 1'b1;
        alu_a = '0; alu_b = '0; alu_sel = '0;
        imem_addr = '0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        dmem_addr = '0; dmem_wdata = '0; dmem_we = 1'b0;
        tick();
        tick();
        imem_addr = 32'd0; dmem_addr = 16'd0;
        expect_out(SEL_INSTR, 32'h0, "rst_imem0");
        expect_out(SEL_DATA, 32'h0, "rst_dmem0");
        #1; drain();
        imem_addr = 32'd200; dmem_addr = 16'd77;
        expect_out(SEL_INSTR, 32'h0, "rst_imem200");
        expect_out(SEL_DATA, 32'h0, "rst_dmem77");
        #1; drain();
        rst = 1'b0;

        // ALU sweep
        alu_chk(32'd7, 32'd5, 4'd0, 32'd12, "add");
        alu_chk(32'd7, 32'd5, 4'd1, 32'd2, "sub");
        alu_chk(32'd7, 32'd5, 4'd4, 32'd5, "and");
        alu_chk(32'd7, 32'd5, 4'd5, 32'd7, "or");
        alu_chk(32'd7, 32'd5, 4'd6, 32'd2, "xor");
        alu_chk(32'd7, 32'd5, 4'd8, 32'hFFFFFFF8, "nor");
        alu_chk(32'd7, 32'd5, 4'd2, 32'd5, "passb");
        expect_out(SEL_EQ, 32'h0, "eq_7_5");
        #1; drain();
        alu_chk(32'd9, 32'd9, 4'd1, 32'd0, "sub_eq");
        expect_out(SEL_EQ, 32'h1, "eq_9_9");
        alu_sel = 4'd0;
        #1; drain();
        alu_chk(32'd7, 32'd5, 4'd3, 32'hFFFFFFF8, "nota");
        alu_chk(32'd7, 32'd5, 4'd12, 32'd7, "passa");
        alu_chk(32'hFFFFFFFF, 32'd5, 4'd13, 32'd0, "inc_wrap");
        alu_chk(32'd0, 32'd5, 4'd14, 32'hFFFFFFFF, "dec_wrap");
        alu_chk(32'd7, 32'd5, 4'd15, 32'd0, "zero_op");
        alu_chk(32'hFFFFFFFF, 32'd1, 4'd7, 32'd1, "slt_neg");
        alu_chk(32'd1, 32'hFFFFFFFF, 4'd7, 32'd0, "slt_pos");
        alu_chk(32'hFFFFFFFF, 32'd1, 4'd1, 32'hFFFFFFFE, "sub_neg");
        alu_chk(32'h80000000, 32'd4, 4'd11, 32'hF8000000, "sra");
        alu_chk(32'h80000000, 32'd4, 4'd9, 32'h08000000, "srl");
        alu_chk(32'd1, 32'd33, 4'd10, 32'd2, "sll_mask");
        alu_chk(32'h80000000, 32'h00000000, 4'd0, 32'h80000000, "add_msb");
        alu_a = 32'h1234_5678; alu_b = 32'h1234_5679;
        expect_out(SEL_EQ, 32'h0, "eq_lsb_diff");
        #1; drain();

        // IMem load and fetch
        imem_we = 1'b1; imem_waddr = 8'd5; imem_wdata = 32'h20010003; imem_addr = 32'd5;
        expect_out(SEL_INSTR, 32'h0, "imem_before_edge");
        #1; drain();
        tick();
        imem_we = 1'b0;
        expect_out(SEL_INSTR, 32'h20010003, "imem_fetch5");
        #1; drain();
        imem_addr = 32'h105;
        expect_out(SEL_INSTR, 32'h20010003, "imem_wrap");
        #1; drain();
        imem_addr = 32'd6;
        expect_out(SEL_INSTR, 32'h0, "imem_unwritten");
        #1; drain();

        // DMem store and load
        dmem_we = 1'b1; dmem_addr = 16'h0010; dmem_wdata = 32'hDEADBEEF;
        expect_out(SEL_DATA, 32'h0, "dmem_before_edge");
        #1; drain();
        tick();
        expect_out(SEL_DATA, 32'hDEADBEEF, "dmem_after_edge");
        #1; drain();
        dmem_we = 1'b0; dmem_wdata = 32'h11111111;
        tick();
        expect_out(SEL_DATA, 32'hDEADBEEF, "dmem_hold");
        #1; drain();
        dmem_addr = 16'h0110;
        expect_out(SEL_DATA, 32'hDEADBEEF, "dmem_wrap");
        #1; drain();
        dmem_addr = 16'h0011;
        expect_out(SEL_DATA, 32'h0, "dmem_neighbor");
        #1; drain();

        // Reset wins over concurrent writes
        rst = 1'b1;
        dmem_we = 1'b1; dmem_addr = 16'd3; dmem_wdata = 32'h55;
        imem_we = 1'b1; imem_waddr = 8'd7; imem_wdata = 32'hCAFEF00D;
        tick();
        rst = 1'b0; dmem_we = 1'b0; imem_we = 1'b0;
        imem_addr = 32'd7;
        expect_out(SEL_DATA, 32'h0, "rst_dmem3");
        expect_out(SEL_INSTR, 32'h0, "rst_imem7");
        #1; drain();
        dmem_addr = 16'h0010; imem_addr = 32'd5;
        expect_out(SEL_DATA, 32'h0, "rst_clears_dmem10");
        expect_out(SEL_INSTR, 32'h0, "rst_clears_imem5");
        #1; drain();

        // Concurrent independent writes
        imem_we = 1'b1; imem_waddr = 8'd10; imem_wdata = 32'hA5A5_0001;
        dmem_we = 1'b1; dmem_addr = 16'd20; dmem_wdata = 32'h5A5A_0002;
        tick();
        imem_we = 1'b0; dmem_we = 1'b0;
        imem_addr = 32'd10;
        expect_out(SEL_INSTR, 32'hA5A5_0001, "conc_imem");
        expect_out(SEL_DATA, 32'h5A5A_0002, "conc_dmem");
        #1; drain();

        // Overwrite an existing word
        dmem_we = 1'b1; dmem_wdata = 32'h0000_BEEF;
        tick();
        dmem_we = 1'b0;
        expect_out(SEL_DATA, 32'h0000_BEEF, "dmem_overwrite");
        #1; drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
